v65_alu_seq: RTL and testbench

- Microprogram sequencer that drives the v65 4-bit accumulator ALU (ports k, d in; cf, zf, nf out).
- Holds a small loadable program and executes one instruction per clock: it issues ALU operations and branches on the ALU flags.
- Sits between the test/host interface and the ALU, and owns the ALU's k and d inputs.

---
 rtl/v65_alu_seq_pkg.sv | 24 ++
 rtl/v65_alu_seq_if.sv | 21 ++
 rtl/v65_prog_mem.sv | 26 ++
 rtl/v65_alu_seq.sv | 101 ++++++++++
 tb/tb_v65_alu_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/v65_alu_seq_pkg.sv
// Shared constants for the v65 ALU microprogram sequencer: opcodes, ALU k codes, hold op, FSM states.
package v65_alu_seq_pkg;
   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_JZ   = 3'b100;
   localparam logic [2:0] OP_JC   = 3'b101;
   localparam logic [2:0] OP_JN   = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [1:0] K_ADD = 2'b00;
   localparam logic [1:0] K_OR  = 2'b01;
   localparam logic [1:0] K_AND = 2'b10;
   localparam logic [1:0] K_XOR = 2'b11;

   // OR with zero leaves q intact but clears cf in the ALU
   localparam logic [1:0] HOLD_K = K_OR;
   localparam logic [3:0] HOLD_D = 4'h0;

   localparam logic [7:0] HALT_WORD = 8'hE0;

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/v65_alu_seq_if.sv
// Host/ALU-facing signal bundle of the sequencer; slave is the sequencer side.
interface v65_alu_seq_if #(parameter int AW = 4);
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;
   logic          start;
   logic          cf, zf, nf;
   logic [1:0]    alu_k;
   logic [3:0]    alu_d;
   logic [AW-1:0] pc;
   logic          busy, done, timeout;

   modport slave (
      input  ld_we, ld_addr, ld_data, start, cf, zf, nf,
      output alu_k, alu_d, pc, busy, done, timeout
   );
   modport master (
      output ld_we, ld_addr, ld_data, start, cf, zf, nf,
      input  alu_k, alu_d, pc, busy, done, timeout
   );
endinterface

// File: rtl/v65_prog_mem.sv
// Program store: 2^AW x 8 registers, async reset to HALT, one sync write port, one comb read port.
module v65_prog_mem
   import v65_alu_seq_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          c,
   input  logic          rn,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);
   logic [7:0] mem [2**AW];

   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= HALT_WORD;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/v65_alu_seq.sv
// Sequencer top: FSM, pc, step counter and decode; issues one ALU op or branch per RUN cycle.
module v65_alu_seq
   import v65_alu_seq_pkg::*;
#(
   parameter int AW        = 4,
   parameter int MAX_STEPS = 255
) (
   input logic          c,
   input logic          rn,
   v65_alu_seq_if.slave bus
);
   typedef logic [AW-1:0] pc_t;
   localparam logic [7:0] LAST_STEP = 8'(MAX_STEPS - 1);

   state_e     state;
   pc_t        pc_q, pc_nxt, tgt;
   logic [7:0] steps;
   logic [7:0] instr;
   logic [2:0] op;
   logic [3:0] imm;
   logic       taken;
   logic       done_q, timeout_q;
   logic       unused_rsvd;

   assign op          = instr[7:5];
   assign imm         = instr[3:0];
   assign unused_rsvd = instr[4];
   assign tgt         = pc_t'(imm);

   v65_prog_mem #(.AW(AW)) u_mem (
      .c     (c),
      .rn    (rn),
      .we    (bus.ld_we && state == ST_IDLE),
      .waddr (bus.ld_addr),
      .wdata (bus.ld_data),
      .raddr (pc_q),
      .rdata (instr)
   );

   always_comb begin
      taken = 1'b0;
      case (op)
         OP_JZ:   taken = bus.zf;
         OP_JC:   taken = bus.cf;
         OP_JN:   taken = bus.nf;
         default: taken = 1'b0;
      endcase
      pc_nxt = taken ? tgt : pc_q + 1'b1;
   end

   // ALU ops have op[2]==0; branches, HALT and IDLE all drive the hold op
   always_comb begin
      bus.alu_k = HOLD_K;
      bus.alu_d = HOLD_D;
      if (state == ST_RUN && !op[2]) begin
         bus.alu_k = op[1:0];
         bus.alu_d = imm;
      end
   end

   always_ff @(posedge c or negedge rn) begin
      if (!rn) begin
         state     <= ST_IDLE;
         pc_q      <= '0;
         steps     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state     <= ST_RUN;
                  pc_q      <= '0;
                  steps     <= '0;
                  done_q    <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            ST_RUN: begin
               steps <= steps + 8'd1;
               if (op == OP_HALT) begin
                  state  <= ST_IDLE;
                  done_q <= 1'b1;
               end else begin
                  pc_q <= pc_nxt;
                  if (steps == LAST_STEP) begin
                     state     <= ST_IDLE;
                     timeout_q <= 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.pc      = pc_q;
   assign bus.busy    = (state == ST_RUN);
   assign bus.done    = done_q;
   assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_v65_alu_seq.sv
// Directed bench for v65_alu_seq with a behavioural 4-bit accumulator ALU closing the flag loop.
module tb_v65_alu_seq;
   logic c = 1'b0;
   logic rn;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc;

   logic [5:0] tr    [16];
   logic       tr_cf [16];

   logic [3:0] q = 4'h0;

   v65_alu_seq_if #(.AW(4)) bus ();

   v65_alu_seq #(.AW(4), .MAX_STEPS(8)) dut (
      .c   (c),
      .rn  (rn),
      .bus (bus)
   );

   always #5 c = ~c;

   initial begin
      bus.cf = 1'b0;
      bus.zf = 1'b0;
      bus.nf = 1'b0;
   end

   // ALU model: registered q and flags; logical ops clear carry
   always @(posedge c) begin
      logic [4:0] s;
      case (bus.alu_k)
         2'b00:   s = {1'b0, q} + {1'b0, bus.alu_d};
         2'b01:   s = {1'b0, q | bus.alu_d};
         2'b10:   s = {1'b0, q & bus.alu_d};
         default: s = {1'b0, q ^ bus.alu_d};
      endcase
      q      <= s[3:0];
      bus.cf <= s[4];
      bus.zf <= (s[3:0] == 4'h0);
      bus.nf <= s[3];
   end

   task automatic tick;
      @(posedge c);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      bus.ld_we   = 1'b1;
      bus.ld_addr = a;
      bus.ld_data = d;
      tick();
      bus.ld_we   = 1'b0;
   endtask

   // Pulses start, then counts RUN cycles (bounded); optionally pokes ld_we/start mid-run
   task automatic run(input bit inject, output int cycles);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      cycles = 0;
      while (bus.busy && cycles < 300) begin
         if (cycles < 16) begin
            tr[cycles]    = {bus.alu_k, bus.alu_d};
            tr_cf[cycles] = bus.cf;
         end
         if (inject && cycles == 1) begin
            bus.ld_we   = 1'b1;
            bus.ld_addr = 4'd1;
            bus.ld_data = 8'hE0;
            bus.start   = 1'b1;
         end else begin
            bus.ld_we = 1'b0;
            bus.start = 1'b0;
         end
         cycles++;
         tick();
      end
      bus.ld_we = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      rn          = 1'b0;
      bus.ld_we   = 1'b0;
      bus.ld_addr = 4'd0;
      bus.ld_data = 8'h00;
      bus.start   = 1'b0;
      tick();
      tick();
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_timeout", bus.timeout, 0);
      chk("rst_pc", bus.pc, 0);
      chk("rst_hold", {bus.alu_k, bus.alu_d}, 6'h10);
      rn = 1'b1;
      tick();

      // 1: AND 0, ADD 3, ADD 5, HALT
      load(4'd0, 8'h40); load(4'd1, 8'h03); load(4'd2, 8'h05); load(4'd3, 8'hE0);
      run(1'b0, cyc);
      chk("t1_cycles", cyc, 4);
      chk("t1_tr0", tr[0], 6'h20);
      chk("t1_tr1", tr[1], 6'h03);
      chk("t1_tr2", tr[2], 6'h05);
      chk("t1_tr3", tr[3], 6'h10);
      chk("t1_q", q, 4'h8);
      chk("t1_done", bus.done, 1);
      chk("t1_timeout", bus.timeout, 0);
      chk("t1_pc", bus.pc, 3);

      // 2: carry from F+1 takes JC over the d=7 op
      load(4'd0, 8'h40); load(4'd1, 8'h2F); load(4'd2, 8'h01);
      load(4'd3, 8'hA5); load(4'd4, 8'h07); load(4'd5, 8'hE0);
      run(1'b0, cyc);
      chk("t2_cycles", cyc, 5);
      chk("t2_cf_at_jc", tr_cf[3], 1);
      chk("t2_jc_hold", tr[3], 6'h10);
      chk("t2_no_d7", tr[4], 6'h10);
      chk("t2_q", q, 4'h0);
      chk("t2_done", bus.done, 1);
      chk("t2_pc", bus.pc, 5);

      // 3: JZ not taken with q=1
      load(4'd0, 8'h40); load(4'd1, 8'h21); load(4'd2, 8'h80); load(4'd3, 8'hE0);
      run(1'b0, cyc);
      chk("t3_cycles", cyc, 4);
      chk("t3_done", bus.done, 1);
      chk("t3_q", q, 4'h1);
      chk("t3_pc", bus.pc, 3);

      // 4: JZ self-loop runs into the 8-step limit
      load(4'd0, 8'h40); load(4'd1, 8'h81);
      run(1'b0, cyc);
      chk("t4_cycles", cyc, 8);
      chk("t4_busy", bus.busy, 0);
      chk("t4_timeout", bus.timeout, 1);
      chk("t4_done", bus.done, 0);
      chk("t4_pc", bus.pc, 1);

      // 5: reset during the second RUN cycle wipes the program
      load(4'd0, 8'h40); load(4'd1, 8'h03); load(4'd2, 8'h05); load(4'd3, 8'hE0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("t5_busy_pre", bus.busy, 1);
      rn = 1'b0;
      #1;
      chk("t5_busy", bus.busy, 0);
      chk("t5_done", bus.done, 0);
      chk("t5_pc", bus.pc, 0);
      #1;
      rn = 1'b1;
      tick();
      run(1'b0, cyc);
      chk("t5_rerun_cycles", cyc, 1);
      chk("t5_rerun_done", bus.done, 1);
      chk("t5_rerun_pc", bus.pc, 0);

      // 6: ld_we/start during RUN are ignored; reload in IDLE takes effect
      load(4'd0, 8'h40); load(4'd1, 8'h81);
      run(1'b1, cyc);
      chk("t6_cycles", cyc, 8);
      chk("t6_timeout", bus.timeout, 1);
      chk("t6_done", bus.done, 0);
      load(4'd1, 8'hE0);
      run(1'b0, cyc);
      chk("t6_reload_cycles", cyc, 2);
      chk("t6_reload_done", bus.done, 1);
      chk("t6_reload_timeout", bus.timeout, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
